// File: rtl/imem_loader.sv
// Boot loader: framed byte stream (LEN_LO, LEN_HI, 4*N little-endian payload bytes) -> imem word writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [31:0]           wdata,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   // S_FIN is the cycle carrying the final write; done rises after it
   localparam logic [2:0] S_FIN    = 3'd4;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK    = 3'd5;
`endif
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   logic [2:0]            state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [23:0]           asm_q, asm_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif
   logic                  accept;
   logic [15:0]           len;

   assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == S_CHK)
`endif
                       ;
   assign accept   = byte_valid & byte_ready;
   assign len      = {byte_data, len_lo_q};
   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;
   assign error    = error_q;

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d     = 1'b0;
               error_d    = 1'b0;
               busy_d     = 1'b1;
               word_idx_d = '0;
               byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = 8'h00;
`endif
               state_d    = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_lo_d = byte_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               if (len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
`endif
               end else if ({1'b0, len} > DEPTH_L) begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  n_d     = len[ADDR_WIDTH:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_data;
`endif
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: asm_d[7:0]   = byte_data;
                  2'd1: asm_d[15:8]  = byte_data;
                  2'd2: asm_d[23:16] = byte_data;
                  default: begin
                     we_d       = 1'b1;
                     waddr_d    = word_idx_q[ADDR_WIDTH-1:0];
                     wdata_d    = {byte_data, asm_q};
                     word_idx_d = word_idx_q + 1'b1;
                     if (word_idx_q + 1'b1 == n_q) begin
                        state_d = S_FIN;
                     end
                  end
               endcase
            end
         end
         S_FIN: begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (byte_data == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         len_lo_q   <= '0;
         n_q        <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Table-driven frame tests for imem_loader with a write scoreboard; honours LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        we;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        busy, cpu_hold, done, error;

   imem_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] n;
      bit          fixed;
      bit          gaps;
      bit          chk_bad;
      bit          start_last;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] fx [8];
   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", {24'h0, waddr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("waddr", {24'h0, waddr}, {24'h0, e.addr});
            check("wdata", wdata, e.data);
            $display("write addr=%0d data=0x%08h", waddr, wdata);
            last_addr = waddr;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
      int t = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      start      = with_start;
      while (!byte_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      logic [7:0]  b;
      logic [7:0]  x = 8'h00;
      logic [31:0] word;
      int          nw;
      int          t = 0;
      pulse_start();
      check({v.name, "_start_busy"}, {29'h0, busy, done, error}, 32'b100);
      send_byte(v.n[7:0], v.gaps, 1'b0);
      send_byte(v.n[15:8], v.gaps, 1'b0);
      nw = (v.n <= DEPTH) ? int'(v.n) : 0;
      for (int w = 0; w < nw; w++) begin
         word = 32'h0;
         for (int k = 0; k < 4; k++) begin
            b = v.fixed ? fx[(w * 4 + k) % 8] : 8'($urandom);
            x ^= b;
            word[8*k +: 8] = b;
            if (k == 3) exp_q.push_back('{addr: 8'(w), data: word});
            send_byte(b, v.gaps, v.start_last && (w == nw - 1) && (k == 3));
         end
      end
`ifndef LOADER_CHECKSUM_EN
      if (nw > 0) begin
         check({v.name, "_last_we"}, {29'h0, we, done, busy}, 32'b101);
         @(posedge clk); #1;
         check({v.name, "_done_edge"}, {29'h0, we, done, busy}, 32'b010);
      end
`else
      send_byte(x ^ (v.chk_bad ? 8'h01 : 8'h00), v.gaps, 1'b0);
`endif
      while (!(done || error) && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      @(posedge clk); #1;
      check({v.name, "_done"}, {31'h0, done}, {31'h0, v.exp_done});
      check({v.name, "_error"}, {31'h0, error}, {31'h0, v.exp_err});
      check({v.name, "_busy"}, {30'h0, busy, cpu_hold}, 32'b00);
      check({v.name, "_ready"}, {31'h0, byte_ready}, 32'h0);
      check({v.name, "_pending"}, exp_q.size(), 32'd0);
      $display("frame %s n=%0d done=%0b error=%0b", v.name, v.n, done, error);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit cen;
`ifdef LOADER_CHECKSUM_EN
      cen = 1'b1;
`else
      cen = 1'b0;
`endif
      fx = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      vecs[0] = '{"two_words",   16'd2,      1, 0, 0, 0, 1, 0};
      vecs[1] = '{"empty",       16'd0,      0, 0, 0, 0, 1, 0};
      vecs[2] = '{"too_long",    16'h0101,   0, 0, 0, 0, 0, 1};
      vecs[3] = '{"full_256",    16'd256,    0, 1, 0, 0, 1, 0};
      vecs[4] = '{"three_rand",  16'd3,      0, 1, 0, 0, 1, 0};
      vecs[5] = '{"max_len",     16'hFFFF,   0, 0, 0, 0, 0, 1};
      vecs[6] = '{"chk_bad",     16'd1,      1, 0, 1, 0, !cen, cen};
      vecs[7] = '{"start_last",  16'd1,      0, 0, 0, 1, 1, 0};
      vecs[8] = '{"empty_badck", 16'd0,      0, 0, 1, 0, !cen, cen};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {25'h0, byte_ready, we, busy, cpu_hold, done, error, 1'b0}, 32'h0);
      check("reset_waddr", {24'h0, waddr}, 32'h0);
      check("reset_wdata", wdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // A byte offered while idle must not be taken
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      check("idle_ready", {30'h0, byte_ready, busy}, 32'h0);
      byte_valid = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i]);
      end
      check("full_last_addr", {24'h0, last_addr}, 32'h0);

      // start during LEN_HI must be ignored
      pulse_start();
      send_byte(8'h01, 1'b0, 1'b0);
      start = 1'b1;
      check("start_while_busy", {31'h0, busy}, 32'h1);
      send_byte(8'h00, 1'b0, 1'b1);
      exp_q.push_back('{addr: 8'h00, data: 32'hDEADBEEF});
      send_byte(8'hEF, 1'b0, 1'b0);
      send_byte(8'hBE, 1'b0, 1'b0);
      send_byte(8'hAD, 1'b0, 1'b0);
      send_byte(8'hDE, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 1'b0, 1'b0);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("ignored_start_done", {29'h0, done, error, busy}, 32'b100);
      check("ignored_start_pending", exp_q.size(), 32'd0);

      // Reset mid-load after five payload bytes
      pulse_start();
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      exp_q.push_back('{addr: 8'h00, data: 32'h44332211});
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0);
      send_byte(8'h44, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {26'h0, byte_ready, we, busy, cpu_hold, done, error}, 32'h0);
      check("midrst_waddr", {24'h0, waddr}, 32'h0);
      check("midrst_wdata", wdata, 32'h0);
      check("midrst_pending", exp_q.size(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
